// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the system RAM arbiter.
//   ADDR_W / DATA_W  : default RAM geometry (64 KiB x 8)
//   arb_state_t      : arbiter sequencing states
//   REQ_*            : default requester slot assignment
//   wrap_inc()       : increment with wrap modulo n
package ram_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ACCESS  = 2'd1,
        ARB_RESPOND = 2'd2
    } arb_state_t;

    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_DMA   = 2;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selection.
//   req        : request vector
//   pointer    : index with the highest priority this round
//   winner     : one-hot of the first requester at or after pointer (wrapping)
//   winner_idx : binary index of that requester
//   any_req    : at least one request is pending
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any_req
);

    // One extra bit so pointer + offset never overflows before the wrap.
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        sum        = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, pointer} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous RAM among NUM_REQ requesters with
// round-robin arbitration, one access per grant.
//   Clock, Reset            : clock (rising edge), async active-high reset
//   Req, Write, Addr, WrData: per-requester request, write flag, address, data
//   Grant                   : one-hot, one cycle, request accepted
//   RspValid, RspData       : one-hot completion strobe and shared read data
//   Busy                    : an access is being sequenced
//   RamAddrIn/RamAddrOut    : RAM write / read address
//   RamDataIn, RamWriteEnable: RAM write data and strobe
//   RamDataOut              : RAM registered read data
//
// state       | meaning
// ------------+--------------------------------------------------------
// ARB_IDLE    | no access in flight; arbitrate on every edge
// ARB_ACCESS  | Grant high, RAM driven; RAM acts on the edge ending it
// ARB_RESPOND | RspValid high, RAM read data returned; arbitrate again
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = ram_pkg::ADDR_W,
    parameter int DATA_W  = ram_pkg::DATA_W
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        Req,
    input  logic [NUM_REQ-1:0]        Write,
    input  logic [NUM_REQ*ADDR_W-1:0] Addr,
    input  logic [NUM_REQ*DATA_W-1:0] WrData,
    output logic [NUM_REQ-1:0]        Grant,
    output logic [NUM_REQ-1:0]        RspValid,
    output logic [DATA_W-1:0]         RspData,
    output logic                      Busy,
    output logic [ADDR_W-1:0]         RamAddrIn,
    output logic [ADDR_W-1:0]         RamAddrOut,
    output logic [DATA_W-1:0]         RamDataIn,
    output logic                      RamWriteEnable,
    input  logic [DATA_W-1:0]         RamDataOut
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t          state;
    logic [IDX_W-1:0]    pointer;
    logic [NUM_REQ-1:0]  owner_oh;

    logic [NUM_REQ-1:0]  win_oh;
    logic [IDX_W-1:0]    win_idx;
    logic                win_any;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic [IDX_W-1:0]    next_pointer;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (Req),
        .pointer    (pointer),
        .winner     (win_oh),
        .winner_idx (win_idx),
        .any_req    (win_any)
    );

    assign win_addr     = Addr[win_idx*ADDR_W +: ADDR_W];
    assign win_data     = WrData[win_idx*DATA_W +: DATA_W];
    assign next_pointer = IDX_W'(wrap_inc(int'(win_idx), NUM_REQ));

    // The RAM output register is the response; no extra pipeline stage.
    assign RspData = RamDataOut;
    assign Busy    = (state != ARB_IDLE);

    // The RAM-side registers double as the latched address/data of the
    // owner; they are loaded only when a new access is accepted.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state          <= ARB_IDLE;
            pointer        <= '0;
            owner_oh       <= '0;
            Grant          <= '0;
            RspValid       <= '0;
            RamAddrIn      <= '0;
            RamAddrOut     <= '0;
            RamDataIn      <= '0;
            RamWriteEnable <= 1'b0;
        end else begin
            Grant          <= '0;
            RspValid       <= '0;
            RamWriteEnable <= 1'b0;
            unique case (state)
                ARB_IDLE, ARB_RESPOND: begin
                    if (win_any) begin
                        state          <= ARB_ACCESS;
                        pointer        <= next_pointer;
                        owner_oh       <= win_oh;
                        Grant          <= win_oh;
                        RamAddrIn      <= win_addr;
                        RamAddrOut     <= win_addr;
                        RamDataIn      <= win_data;
                        RamWriteEnable <= Write[win_idx];
                    end else begin
                        state <= ARB_IDLE;
                    end
                end
                ARB_ACCESS: begin
                    state    <= ARB_RESPOND;
                    RspValid <= owner_oh;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter with a behavioural
// synchronous RAM (read-before-write) and a response scoreboard.
module tb_ram_arbiter;
    import ram_pkg::*;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 8;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [N-1:0]      req;
    logic [N-1:0]      wr;
    logic [AW-1:0]     addr [N];
    logic [DW-1:0]     wdata [N];
    logic [N*AW-1:0]   addr_flat;
    logic [N*DW-1:0]   wdata_flat;

    logic [N-1:0]      Grant;
    logic [N-1:0]      RspValid;
    logic [DW-1:0]     RspData;
    logic              Busy;
    logic [AW-1:0]     RamAddrIn;
    logic [AW-1:0]     RamAddrOut;
    logic [DW-1:0]     RamDataIn;
    logic              RamWriteEnable;
    logic [DW-1:0]     RamDataOut;

    logic [DW-1:0]     mem     [65536];
    logic [DW-1:0]     ref_mem [65536];

    always_comb begin
        addr_flat  = '0;
        wdata_flat = '0;
        for (int i = 0; i < N; i++) begin
            addr_flat[i*AW +: AW]  = addr[i];
            wdata_flat[i*DW +: DW] = wdata[i];
        end
    end

    ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Req            (req),
        .Write          (wr),
        .Addr           (addr_flat),
        .WrData         (wdata_flat),
        .Grant          (Grant),
        .RspValid       (RspValid),
        .RspData        (RspData),
        .Busy           (Busy),
        .RamAddrIn      (RamAddrIn),
        .RamAddrOut     (RamAddrOut),
        .RamDataIn      (RamDataIn),
        .RamWriteEnable (RamWriteEnable),
        .RamDataOut     (RamDataOut)
    );

    always #5 Clock = ~Clock;

    // Synchronous RAM: registered read of the old contents, write on the same edge.
    always @(posedge Clock) begin
        if (RamWriteEnable) mem[RamAddrIn] <= RamDataIn;
        RamDataOut <= mem[RamAddrOut];
    end

    typedef struct {
        logic [N-1:0]  rsp;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  wr;
        logic [DW-1:0] wd;
        logic [N-1:0]  exp_grant;
    } vec_t;
    vec_t vt [10];

    int           n_vec = 0;
    int           n_err = 0;
    int           cycle = 0;
    int           we_cycles = 0;
    logic [N-1:0] last_grant;
    bit           auto_drop = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // One clock: sample at the falling edge, track grants into the
    // scoreboard and retire responses against it.
    task automatic tick();
        exp_t e;
        int   idx;
        @(negedge Clock);
        cycle++;
        last_grant = Grant;
        if (RamWriteEnable) we_cycles++;
        if (!Reset) begin
            if (Grant != '0) begin
                check("grant_onehot", 32'($onehot(Grant)), 1);
                idx = 0;
                for (int i = 0; i < N; i++) if (Grant[i]) idx = i;
                check("grant_req", 32'(req[idx]), 1);
                check("ram_addr", {RamAddrIn, RamAddrOut}, {addr[idx], addr[idx]});
                check("ram_we", 32'(RamWriteEnable), 32'(wr[idx]));
                if (wr[idx]) check("ram_wdata", 32'(RamDataIn), 32'(wdata[idx]));
                e.rsp  = Grant;
                e.data = ref_mem[addr[idx]];
                sb.push_back(e);
                if (wr[idx]) ref_mem[addr[idx]] = wdata[idx];
                if (auto_drop) req[idx] = 1'b0;
            end else if (RamWriteEnable) begin
                check("we_outside_access", 32'(RamWriteEnable), 0);
            end
            if (RspValid != '0) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got RspValid %b, required none outstanding", RspValid);
                end else begin
                    e = sb.pop_front();
                    check("rsp_valid", 32'(RspValid), 32'(e.rsp));
                    check("rsp_data", 32'(RspData), 32'(e.data));
                end
            end
        end
    endtask

    task automatic wait_grant(input int budget, output logic [N-1:0] g);
        g = '0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (last_grant != '0) begin
                g = last_grant;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL grant_timeout: got no Grant in %0d cycles, required one", budget);
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (!Busy && sb.size() == 0) return;
            tick();
        end
        n_vec++;
        n_err++;
        $display("FAIL drain_timeout: got Busy=%b outstanding=%0d, required idle", Busy, sb.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]  g;
        logic [N-1:0]  glog [6];
        int            gcyc [6];
        int            ng;
        logic [DW-1:0] old;

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[16'h1234] = 8'hA5;  ref_mem[16'h1234] = 8'hA5;
        mem[16'hFFFF] = 8'h77;  ref_mem[16'hFFFF] = 8'h77;

        vt[0] = '{3'b111, 3'b000, 8'h00, 3'b001};
        vt[1] = '{3'b101, 3'b100, 8'h11, 3'b100};
        vt[2] = '{3'b110, 3'b010, 8'h20, 3'b010};
        vt[3] = '{3'b011, 3'b000, 8'h00, 3'b001};
        vt[4] = '{3'b001, 3'b001, 8'h30, 3'b001};
        vt[5] = '{3'b010, 3'b000, 8'h00, 3'b010};
        vt[6] = '{3'b111, 3'b000, 8'h00, 3'b100};
        vt[7] = '{3'b100, 3'b000, 8'h00, 3'b100};
        vt[8] = '{3'b010, 3'b000, 8'h00, 3'b010};
        vt[9] = '{3'b101, 3'b000, 8'h00, 3'b100};

        Reset = 1'b1;
        req   = '0;
        wr    = '0;
        for (int i = 0; i < N; i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
        end

        // Reset state
        #1;
        check("rst_outputs", {Grant, RspValid, 7'd0, Busy, RamWriteEnable}, 0);
        check("rst_ram_bus", {RamAddrIn, RamAddrOut}, 0);
        check("rst_ram_data", 32'(RamDataIn), 0);
        tick();
        tick();
        Reset = 1'b0;

        // Single read
        addr[REQ_DATA] = 16'h1234;
        req = 3'b010;
        tick();
        check("single_grant", 32'(last_grant), 32'(3'b010));
        tick();
        check("single_rsp_valid", 32'(RspValid), 32'(3'b010));
        check("single_rsp_data", 32'(RspData), 32'h A5);
        tick();
        check("single_busy_after", 32'(Busy), 0);

        // Write then read, requester 2, top address
        we_cycles      = 0;
        addr[REQ_DMA]  = 16'hFFFF;
        wdata[REQ_DMA] = 8'h3C;
        wr  = 3'b100;
        req = 3'b100;
        wait_grant(8, g);
        check("wr_grant", 32'(g), 32'(3'b100));
        tick();
        check("wr_rsp_old", 32'(RspData), 32'h77);
        wr  = 3'b000;
        req = 3'b100;
        wait_grant(8, g);
        tick();
        check("rd_after_wr", 32'(RspData), 32'h3C);
        check("we_one_cycle", we_cycles, 1);
        drain();

        // Table of arbitration patterns; pointer carries across entries
        for (int v = 0; v < 10; v++) begin
            wr = vt[v].wr;
            for (int i = 0; i < N; i++) begin
                addr[i]  = 16'h0100 + 16'(i);
                wdata[i] = vt[v].wd + 8'(i);
            end
            req = vt[v].req;
            wait_grant(8, g);
            check($sformatf("table_grant_%0d", v), 32'(g), 32'(vt[v].exp_grant));
            req = '0;
            drain();
        end

        // Continuous contention: rotating grants, one every 2 cycles
        auto_drop = 1'b0;
        wr = '0;
        for (int i = 0; i < N; i++) addr[i] = 16'h0200 + 16'(i);
        req = 3'b111;
        ng  = 0;
        for (int k = 0; k < 30 && ng < 6; k++) begin
            tick();
            if (last_grant != '0) begin
                glog[ng] = last_grant;
                gcyc[ng] = cycle;
                ng++;
            end
        end
        req = '0;
        check("contend_count", ng, 6);
        for (int k = 0; k < ng; k++) begin
            check($sformatf("contend_grant_%0d", k), 32'(glog[k]), 32'(3'b001 << (k % 3)));
            if (k > 0) check($sformatf("contend_spacing_%0d", k), gcyc[k] - gcyc[k-1], 2);
        end
        auto_drop = 1'b1;
        drain();

        // Idle hold
        for (int k = 0; k < 20; k++) begin
            tick();
            check("idle_hold", {Busy, RamWriteEnable, Grant, RspValid}, 0);
        end

        // Reset in the middle of a write access
        old             = ref_mem[16'h0010];
        addr[REQ_DATA]  = 16'h0010;
        wdata[REQ_DATA] = 8'h5A ^ old;
        wr  = 3'b010;
        req = 3'b010;
        wait_grant(8, g);
        check("mid_grant", 32'(g), 32'(3'b010));
        #1 Reset = 1'b1;
        #1;
        check("mid_rst_drop", {Grant, RspValid, 6'd0, RamWriteEnable, Busy}, 0);
        sb.delete();
        ref_mem[16'h0010] = old;
        tick();
        tick();
        Reset = 1'b0;
        wr    = '0;
        for (int k = 0; k < 4; k++) tick();
        check("mid_no_write", 32'(mem[16'h0010]), 32'(old));
        addr[REQ_DATA] = 16'h0300;
        addr[REQ_DMA]  = 16'h0301;
        req = 3'b110;
        wait_grant(8, g);
        check("post_rst_grant", 32'(g), 32'(3'b010));
        req = '0;
        drain();

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
